// File: rtl/dm_pkg.sv
// Shared definitions for the byte-lane data memory.
//   size_t     : access size encodings as carried on the 'size' port
//   state_t    : clear-sequencer states
//   is_aligned : legality of an access given its size and low address bits
package dm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (size_t'(size))
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational byte-lane steering for dm_bytelane.
//   size  : access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   off   : byte offset within the word (addr[1:0])
//   din   : right-aligned store data
//   rword : word currently stored at the addressed index
//   uns   : 1 = zero-extend sub-word loads, 0 = sign-extend
//   be    : per-lane write enables for a store
//   wdata : store data replicated across lanes; 'be' picks the live lanes
//   rdata : extended load result
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] din,
    input  logic [31:0] rword,
    input  logic        uns,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        be    = '0;
        wdata = '0;
        rdata = '0;
        bsel  = rword[{off, 3'b000} +: 8];
        hsel  = off[1] ? rword[31:16] : rword[15:0];

        case (size_t'(size))
            SZ_BYTE: begin
                be    = 4'b0001 << off;
                wdata = {4{din[7:0]}};
                rdata = {{24{~uns & bsel[7]}}, bsel};
            end
            SZ_HALF: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
                rdata = {{16{~uns & hsel[15]}}, hsel};
            end
            SZ_WORD: begin
                be    = '1;
                wdata = din;
                rdata = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_bytelane.sv
// Single-port data memory with byte/half/word access and post-reset clear.
//   clk, rst  : clock; synchronous active-high reset
//   req       : access request
//   dmwr      : 1 = store, 0 = load
//   size      : 00 byte, 01 half, 10 word, 11 illegal
//   uns       : zero-extend (1) or sign-extend (0) sub-word loads
//   addr      : byte address; word index is addr[AW-1:2]
//   din       : right-aligned store data
//   dout      : registered load result, holds between loads
//   rvalid    : one-cycle pulse when dout is updated
//   misalign  : one-cycle pulse for a rejected access
//   busy      : clear sequence running; requests are dropped
module dm_bytelane
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned AW             = $clog2(DEPTH) + 2,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          dmwr,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout,
    output logic          rvalid,
    output logic          misalign,
    output logic          busy
);

    localparam int unsigned IW = AW - 2;

    logic [31:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          clr_we;

    logic [IW-1:0] idx;
    logic [1:0]    off;
    logic          legal;
    logic          accept;
    logic          reject;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    assign idx  = addr[AW-1:2];
    assign off  = addr[1:0];
    assign busy = (state_q == CLEAR);

    // Requests coinciding with rst are ignored along with those seen while busy.
    assign legal  = is_aligned(size, off);
    assign accept = req & ~rst & ~busy & legal;
    assign reject = req & ~rst & ~busy & ~legal;

    dm_lane u_lane (
        .size  (size),
        .off   (off),
        .din   (din),
        .rword (mem[idx]),
        .uns   (uns),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == IW'(DEPTH - 1))
                    state_d = READY;
            end
            READY: ;
            default: state_d = READY;
        endcase
    end

    // Clearing and accesses never overlap: accept requires the READY state.
    always_ff @(posedge clk) begin
        if (clr_we && !rst) begin
            mem[ptr_q] <= '0;
        end else if (accept && dmwr) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be[k])
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            rvalid   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            rvalid   <= accept & ~dmwr;
            misalign <= reject;
            if (accept && !dmwr)
                dout <= rdata;
        end
    end

endmodule
